// File: rtl/st7920_framebuffer_if.sv
// Command bus for the ST7920 framebuffer.
//   cmd_valid / cmd_ready : handshake, transfer on sys_clk rise when both high
//   cmd_op                : 0 NOP, 1 SET, 2 CLR, 3 XOR, 4 WRBYTE, 5 FILL, 6/7 NOP
//   cmd_x, cmd_y          : pixel column (0..127) / row (0..63)
//   cmd_data              : byte for WRBYTE, pattern for FILL
// master drives commands; slave is the framebuffer.
interface st7920_framebuffer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [6:0] cmd_x;
  logic [5:0] cmd_y;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/st7920_framebuffer.sv
// 128x64 monochrome framebuffer feeding the ST7920 serial driver.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   cmd                : command bus (slave side)
//   dirty_clr          : clears the dirty flag (a coincident write wins)
//   memory[0:DEPTH-1]  : framebuffer bytes, GDRAM order, byte = y*16 + x/8,
//                        MSB is the leftmost pixel
//   busy               : whole-screen fill in progress
//   dirty              : contents changed since the last dirty_clr
module st7920_framebuffer #(
  parameter  int unsigned BYTES_PER_ROW = 16,
  parameter  int unsigned ROWS          = 64,
  localparam int unsigned DEPTH         = BYTES_PER_ROW * ROWS
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  st7920_framebuffer_if.slave  cmd,
  input  logic                 dirty_clr,
  output logic [7:0]           memory [0:DEPTH-1],
  output logic                 busy,
  output logic                 dirty
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_CLR    = 3'd2;
  localparam logic [2:0] OP_XOR    = 3'd3;
  localparam logic [2:0] OP_WRBYTE = 3'd4;
  localparam logic [2:0] OP_FILL   = 3'd5;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] fill_cnt;
  logic [7:0]    fill_pat;
  logic          armed;     // low only until the first clock after reset release
  logic          accept;
  logic          pix_op;
  logic          dirty_set;
  logic [AW-1:0] addr;
  logic [7:0]    mask;
  logic [7:0]    rmw_byte;

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && cmd.cmd_op == OP_FILL) state_nxt = S_FILL;
      S_FILL: if (fill_cnt == AW'(DEPTH - 1))      state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    cmd.cmd_ready = (state == S_IDLE) && armed;
    busy          = (state == S_FILL);
  end

  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign addr   = {cmd.cmd_y, cmd.cmd_x[6:3]};

  // Read side of the read-modify-write. memory is registered, so a command in
  // the cycle after a write already reads the committed byte: no bypass needed.
  always_comb begin
    mask     = 8'h80 >> cmd.cmd_x[2:0];
    rmw_byte = memory[addr];
    pix_op   = 1'b0;
    case (cmd.cmd_op)
      OP_SET:    begin rmw_byte = memory[addr] | mask;  pix_op = 1'b1; end
      OP_CLR:    begin rmw_byte = memory[addr] & ~mask; pix_op = 1'b1; end
      OP_XOR:    begin rmw_byte = memory[addr] ^ mask;  pix_op = 1'b1; end
      OP_WRBYTE: begin rmw_byte = cmd.cmd_data;         pix_op = 1'b1; end
      default:   ;
    endcase
  end

  assign dirty_set = (accept && pix_op) || (state == S_FILL);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) memory[i] <= '0;
    end else if (state == S_FILL) begin
      memory[fill_cnt] <= fill_pat;
    end else if (accept && pix_op) begin
      memory[addr] <= rmw_byte;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      fill_cnt <= '0;
      fill_pat <= '0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (state == S_FILL) begin
        fill_cnt <= fill_cnt + 1'b1;
      end else if (accept && cmd.cmd_op == OP_FILL) begin
        fill_cnt <= '0;
        fill_pat <= cmd.cmd_data;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     dirty <= 1'b0;
    else if (dirty_set) dirty <= 1'b1;
    else if (dirty_clr) dirty <= 1'b0;
  end

endmodule

// File: doc/st7920_framebuffer.md
Name: st7920_framebuffer

Overview:
- Upstream stage of the ST7920 serial driver. Owns the 128x64 monochrome framebuffer and exposes it as the `memory[0:1023]` byte array that the driver streams to the LCD.
- Accepts drawing commands over a valid/ready handshake: pixel set, clear and toggle, single-byte write, and whole-screen fill.
- A dirty flag tells the display side that the contents have changed since it was last cleared.

Parameters:
- BYTES_PER_ROW, 16, bytes per pixel row (128 px / 8).
- ROWS, 64, pixel rows.
- DEPTH, BYTES_PER_ROW*ROWS (1024), framebuffer bytes. Derived; do not override.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  3  opcode: 0 NOP, 1 SET, 2 CLR, 3 XOR, 4 WRBYTE, 5 FILL, 6/7 reserved (treated as NOP).
- cmd_x  input  7  pixel column 0..127. For WRBYTE only bits [6:3] are used.
- cmd_y  input  6  pixel row 0..63.
- cmd_data  input  8  byte for WRBYTE; pattern for FILL.
- dirty_clr  input  1  clears the dirty flag.
- memory  output  8 x DEPTH  framebuffer contents, unpacked array [0:1023] of bytes.
- busy  output  1  fill in progress.
- dirty  output  1  framebuffer modified since the last dirty_clr.

Behaviour:
- Address map, matching the ST7920 GDRAM order used by the driver:
  - byte index = cmd_y*16 + cmd_x[6:3].
  - bit = 7 - cmd_x[2:0] (MSB is the leftmost pixel).
  - Rows 0..31 occupy bytes 0..511; rows 32..63 occupy bytes 512..1023.
- Reset (async assert, sync release):
  - all memory bytes 0x00;
  - state IDLE, fill counter 0;
  - cmd_ready=0 while in reset, 1 in the first cycle after release;
  - busy=0, dirty=0.
- A command is accepted on a sys_clk rising edge when cmd_valid && cmd_ready.
- State machine, IDLE:
  - cmd_ready=1.
  - SET/CLR/XOR/WRBYTE: read-modify-write of one byte. The result is visible on `memory` the cycle after acceptance (1-cycle latency).
  - Back-to-back pixel commands are accepted every cycle. A command that targets the byte written by the previous cycle's command must see the updated value (no lost updates).
  - NOP and reserved opcodes are accepted with no effect and do not set dirty.
  - FILL: latch cmd_data as the pattern, clear the counter, go to FILL.
- State machine, FILL:
  - cmd_ready=0, busy=1.
  - Each cycle writes the pattern to memory[counter], then counter += 1.
  - After writing index 1023 (counter wrap 1023->0), return to IDLE.
  - Bytes 0..1023 are written in ascending order, one per cycle, over exactly 1024 cycles starting the cycle after acceptance.
  - cmd_ready returns to 1 in the cycle after index 1023 is written.
  - cmd_valid is ignored during FILL; the upstream producer must hold its command until it is accepted.
- Dirty flag:
  - Set in the cycle a SET/CLR/WRBYTE/XOR write commits, and on every FILL write cycle.
  - Cleared by dirty_clr.
  - If a set and dirty_clr coincide, the set wins and dirty stays 1.
  - SET of an already-set pixel, or CLR of an already-clear pixel, still sets dirty.
- Widths:
  - cmd_x and cmd_y cover the full screen, so no out-of-range case exists.
  - The 10-bit byte index is formed as {cmd_y, cmd_x[6:3]}.
- Reset during FILL: abort immediately. Memory is all 0x00 regardless of progress, state IDLE, busy=0.
- memory is driven only from flops; there is no combinational path from the cmd_* inputs to memory.

Test Plan:
- Release reset, SET (x=0,y=0) then SET (x=127,y=63) → memory[0]=0x80, memory[1023]=0x01, each visible 1 cycle after acceptance; dirty=1.
- SET (x=10,y=33) then XOR (x=10,y=33) on consecutive cycles → memory[33*16+1]=0x20 for one cycle, then 0x00. Verifies the RMW forwarding.
- WRBYTE data=0xA5, x=40 (byte 5), y=31 → memory[501]=0xA5. dirty_clr asserted in the same cycle as the write → dirty stays 1; dirty_clr alone next cycle → dirty=0.
- FILL 0xFF → busy=1 and cmd_ready=0 for exactly 1024 cycles, bytes written in ascending order. A SET held on cmd_valid throughout is accepted only on the first ready cycle afterwards. All bytes 0xFF at the end.
- FILL 0x55, assert sys_rst_n=0 at counter=300 → immediate all-zero memory, busy=0, dirty=0. After release, cmd_ready=1 and a CLR (x=0,y=0) is accepted normally.
- Reserved op 6 and NOP accepted while dirty=0 → memory unchanged, dirty stays 0.
